// File: rtl/da_pkg.sv
// Shared constants, state encoding and helpers for the DA FIR output serializer.
package da_pkg;

  localparam int DA_DATA_W    = 17;
  localparam int DA_FRAME_LEN = 8;
  localparam int DA_LANES     = 3;
  localparam int DA_DEPTH     = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Number of LANES-wide beats needed to carry a w-bit word.
  function automatic int da_beats(input int w, input int l);
    return (w + l - 1) / l;
  endfunction

endpackage

// File: rtl/da_res_fifo.sv
// Small synchronous result FIFO. A push while full is accepted when a pop
// happens in the same cycle, because the pop frees the slot first.
module da_res_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s, wr_en_s, rd_en_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign wr_en_s = push_i & (~full_s | pop_i);
  assign rd_en_s = pop_i & ~empty_s;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_q;

endmodule

// File: rtl/da_result_serializer.sv
// Output end of the DA FIR datapath: buffers each signed result and shifts it
// out MSB group first on a LANES-wide bus with a per-word sync strobe.
module da_result_serializer
  import da_pkg::*;
#(
  parameter int DATA_W = DA_DATA_W,
  parameter int LANES  = DA_LANES,
  parameter int DEPTH  = DA_DEPTH
) (
  input  logic              clk_bit,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] res_in,
  input  logic              res_valid,
  input  logic              ser_en,
  output logic [LANES-1:0]  ser_out,
  output logic              ser_sync,
  output logic              ser_valid,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  localparam int BEATS = da_beats(DATA_W, LANES);
  localparam int W     = BEATS * LANES;
  localparam int BCW   = $clog2(DA_FRAME_LEN);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [BCW-1:0] LAST_BC = BCW'(BEATS - 1);

  ser_state_e     state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           sync_q, sync_d;
  logic           valid_q, valid_d;
  logic [LANES-1:0] out_q, out_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     drop_q, drop_d;
  logic           busy_q, busy_d;

  logic [DATA_W-1:0] fifo_rdata_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CW-1:0]     fifo_cnt_s;
  logic [CW:0]       cnt_nxt_s;
  logic              pop_s, accept_s, drop_s;
  logic [W-1:0]      word_s;

  assign word_s = W'(signed'(fifo_rdata_s));

  da_res_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_bit),
    .rst_ni  (rst_n),
    .push_i  (accept_s),
    .wdata_i (res_in),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_cnt_s)
  );

  // Word sequencing: load from FIFO, shift per accepted beat, chain words with no gap.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bc_d    = bc_q;
    sync_d  = sync_q;
    valid_d = valid_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          sr_d    = word_s;
          bc_d    = {BCW{1'b0}};
          sync_d  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          sync_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!ser_en) begin
          state_d = ST_SHIFT;
        end else if (bc_q != LAST_BC) begin
          sr_d   = {sr_q[W-LANES-1:0], {LANES{1'b0}}};
          bc_d   = bc_q + BCW'(1'b1);
          sync_d = 1'b0;
        end else if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          sr_d    = word_s;
          bc_d    = {BCW{1'b0}};
          sync_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          sr_d    = {W{1'b0}};
          bc_d    = {BCW{1'b0}};
          sync_d  = 1'b0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        sr_d    = {W{1'b0}};
        bc_d    = {BCW{1'b0}};
        sync_d  = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (valid_d) begin
      out_d = sr_d[W-1 -: LANES];
    end else begin
      out_d = {LANES{1'b0}};
    end
  end

  // Push acceptance, drop accounting and activity flag.
  always_comb begin
    accept_s  = res_valid & (~fifo_full_s | pop_s);
    drop_s    = res_valid & fifo_full_s & ~pop_s;
    ovf_d     = ovf_q | drop_s;
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
    cnt_nxt_s = (CW+1)'(fifo_cnt_s) + (CW+1)'(accept_s) - (CW+1)'(pop_s);
    busy_d    = (state_d == ST_SHIFT) || (cnt_nxt_s != {(CW+1){1'b0}});
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= {W{1'b0}};
      bc_q    <= {BCW{1'b0}};
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= {LANES{1'b0}};
      ovf_q   <= 1'b0;
      drop_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bc_q    <= bc_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign ser_out   = out_q;
  assign ser_sync  = sync_q;
  assign ser_valid = valid_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_da_result_serializer.sv
// Bench for da_result_serializer: table-driven single words, a streaming run,
// stall/overflow, mid-word reset and full-FIFO push-on-pop corner.
module tb_da_result_serializer;

  logic        clk_bit = 1'b0;
  logic        rst_n;
  logic [16:0] res_in;
  logic        res_valid;
  logic        ser_en;
  logic [2:0]  ser_out;
  logic        ser_sync;
  logic        ser_valid;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        busy;

  da_result_serializer dut (
    .clk_bit   (clk_bit),
    .rst_n     (rst_n),
    .res_in    (res_in),
    .res_valid (res_valid),
    .ser_en    (ser_en),
    .ser_out   (ser_out),
    .ser_sync  (ser_sync),
    .ser_valid (ser_valid),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk_bit = ~clk_bit;

  typedef struct {
    logic [16:0]      res;
    logic [5:0][2:0]  beats;
  } vec_t;

  vec_t        vecs [6];
  logic [3:0]  exp_q [$];
  logic [3:0]  mon_e;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          gap_chk = 1'b0;
  bit          prev_valid = 1'b0;
  int          gap_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sign-extend to 18 bits and take 3-bit group k from the MSB end.
  function automatic logic [2:0] beat_of(input logic [16:0] v, input int k);
    logic [17:0] w;
    w = {v[16], v};
    return w[17-3*k -: 3];
  endfunction

  task automatic expect_word(input logic [16:0] v);
    for (int k = 0; k < 6; k++) exp_q.push_back({(k == 0), beat_of(v, k)});
  endtask

  task automatic push_word(input logic [16:0] v);
    res_in    = v;
    res_valid = 1'b1;
    @(posedge clk_bit); #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_bit);
    end
    @(posedge clk_bit); #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Push one word, check one-cycle load latency and sync on the first beat.
  task automatic send_checked(input logic [16:0] v, input logic [5:0][2:0] bt);
    for (int k = 0; k < 6; k++) exp_q.push_back({(k == 0), bt[5-k]});
    push_word(v);
    @(negedge clk_bit);
    chk("lat_pre_valid", ser_valid, 0);
    @(negedge clk_bit);
    chk("lat_valid", ser_valid, 1);
    chk("lat_sync", ser_sync, 1);
    wait_drain(20);
  endtask

  // Scoreboard monitor: compares every accepted beat, checks idle zeros and word gaps.
  always @(negedge clk_bit) begin
    if (mon_en && rst_n) begin
      if (!ser_valid) begin
        chk("idle_out_zero", {29'd0, ser_out}, 32'd0);
        gap_cnt = gap_cnt + 1;
      end else begin
        if (!prev_valid) begin
          if (gap_chk && gap_cnt < 50) chk("word_gap", gap_cnt, 2);
          gap_cnt = 0;
        end
        if (ser_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat: got unexpected beat %0d, want none", ser_out);
          end else begin
            mon_e = exp_q.pop_front();
            chk("beat", {28'd0, ser_sync, ser_out}, {28'd0, mon_e});
          end
        end
      end
      prev_valid = ser_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] v;
    logic [16:0] w [4];

    vecs[0].res = 17'h12345; vecs[0].beats = {3'd6, 3'd2, 3'd1, 3'd5, 3'd0, 3'd5};
    vecs[1].res = 17'h1FFFF; vecs[1].beats = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    vecs[2].res = 17'h00001; vecs[2].beats = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    vecs[3].res = 17'h10000; vecs[3].beats = {3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[4].res = 17'h0FFFF; vecs[4].beats = {3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    vecs[5].res = 17'h0AAAA; vecs[5].beats = {3'd1, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2};

    // Reset with a push held high.
    rst_n = 1'b0; res_valid = 1'b1; res_in = 17'h12345; ser_en = 1'b1;
    repeat (3) @(posedge clk_bit); #1;
    chk("rst_valid", ser_valid, 0);
    chk("rst_out", {29'd0, ser_out}, 32'd0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("rst_busy", busy, 0);
    res_valid = 1'b0;
    @(negedge clk_bit); rst_n = 1'b1;
    @(posedge clk_bit); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) send_checked(vecs[i].res, vecs[i].beats);

    // Streaming: one push per 8-cycle frame.
    for (int i = 0; i < 50; i++) begin
      v = 17'($urandom);
      expect_word(v);
      push_word(v);
      repeat (7) @(posedge clk_bit); #1;
      if (i == 0) gap_chk = 1'b1;
    end
    wait_drain(50);
    gap_chk = 1'b0;
    chk("stream_overflow", overflow, 0);
    chk("stream_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Downstream stall: one word in the shifter, two in the FIFO, fourth dropped.
    ser_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 17'($urandom);
      if (i < 3) expect_word(w[i]);
      push_word(w[i]);
      repeat (7) @(posedge clk_bit); #1;
    end
    repeat (8) @(posedge clk_bit); #1;
    chk("stall_overflow", overflow, 1);
    chk("stall_drop_cnt", {24'd0, drop_cnt}, 32'd1);
    chk("stall_busy", busy, 1);
    chk("stall_valid", ser_valid, 1);
    chk("stall_sync", ser_sync, 1);
    chk("stall_hold_out", {29'd0, ser_out}, {29'd0, beat_of(w[0], 0)});
    chk("stall_pending", exp_q.size(), 18);
    ser_en = 1'b1;
    repeat (18) @(posedge clk_bit); #1;
    chk("b2b_all_sent", exp_q.size(), 0);
    chk("b2b_valid_end", ser_valid, 0);
    chk("b2b_busy_end", busy, 0);

    // Reset pulse while beat 3 is on the bus.
    expect_word(17'h12345);
    push_word(17'h12345);
    repeat (4) @(posedge clk_bit);
    @(negedge clk_bit); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ser_valid, 0);
    chk("arst_out", {29'd0, ser_out}, 32'd0);
    chk("arst_sync", ser_sync, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    exp_q.delete();
    @(negedge clk_bit); rst_n = 1'b1;
    @(posedge clk_bit); #1;
    send_checked(vecs[0].res, vecs[0].beats);

    // Full FIFO receives a push in the cycle the last beat pops the next word.
    ser_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = 17'($urandom);
      expect_word(w[i]);
      push_word(w[i]);
    end
    ser_en = 1'b1;
    repeat (5) @(posedge clk_bit); #1;
    w[3] = 17'($urandom);
    expect_word(w[3]);
    push_word(w[3]);
    chk("popfull_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("popfull_overflow", overflow, 0);
    wait_drain(40);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
